// File: rtl/rx_pkg.sv
// Shared definitions for the RX I/Q packer: FSM states, format constants and
// the sign-extend / truncate helpers used when building lanes.
package rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic MODE_IQ16 = 1'b0;
  localparam logic MODE_IQ8  = 1'b1;

  // Sign-extend a w-bit two's complement value held in the low bits of v
  function automatic logic [15:0] sext16(input logic [15:0] v, input int w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      r[b] = (b < w) ? v[b] : v[w-1];
    end
    return r;
  endfunction

  // Keep the top 8 bits of a w-bit sample, plain truncation
  function automatic logic [7:0] trunc8(input logic [15:0] v, input int w);
    return v[w-1 -: 8];
  endfunction

endpackage

// File: rtl/iq_lane_fmt.sv
// Combinational lane formatter: turns one I/Q pair into a full 32-bit word of
// two 16-bit lanes and a 16-bit half-word of two 8-bit lanes.
module iq_lane_fmt
  import rx_pkg::*;
#(
  parameter int IQ_W    = 12,
  parameter bit SWAP_IQ = 1'b0
) (
  input  logic [IQ_W-1:0] smp_i,
  input  logic [IQ_W-1:0] smp_q,
  output logic [31:0]     word16,
  output logic [15:0]     pair8
);

  logic [15:0] i_ext;
  logic [15:0] q_ext;
  logic [7:0]  i_8;
  logic [7:0]  q_8;

  // Widen both samples, derive 8-bit lanes, and order lanes (Q high unless swapped)
  always_comb begin
    i_ext = sext16(16'(smp_i), IQ_W);
    q_ext = sext16(16'(smp_q), IQ_W);
    i_8   = trunc8(i_ext, IQ_W);
    q_8   = trunc8(q_ext, IQ_W);
    if (SWAP_IQ) begin
      word16 = {i_ext, q_ext};
      pair8  = {i_8, q_8};
    end else begin
      word16 = {q_ext, i_ext};
      pair8  = {q_8, i_8};
    end
  end

endmodule

// File: rtl/rx_iq_packer.sv
// RX I/Q packer: sync-aligned capture of I/Q samples into 32-bit words for the
// S->AXI bridge write port, with sample and word counters for status.
module rx_iq_packer
  import rx_pkg::*;
#(
  parameter int IQ_W    = 12,
  parameter bit SWAP_IQ = 1'b0
) (
  input  logic            Sclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic            sync,
  input  logic [IQ_W-1:0] rx_i,
  input  logic [IQ_W-1:0] rx_q,
  input  logic            rx_valid,
  output logic [31:0]     dout,
  output logic            dout_en,
  output logic            armed,
  output logic            running,
  output logic [31:0]     smp_cnt,
  output logic [31:0]     word_cnt
);

  state_t      state;
  state_t      state_nxt;
  logic        mode_q;
  logic        phase;
  logic [15:0] hold;
  logic        arm_entry;
  logic        align;
  logic        accept;
  logic [31:0] word16;
  logic [15:0] pair8;

  iq_lane_fmt #(
    .IQ_W    (IQ_W),
    .SWAP_IQ (SWAP_IQ)
  ) u_fmt (
    .smp_i  (rx_i),
    .smp_q  (rx_q),
    .word16 (word16),
    .pair8  (pair8)
  );

  // Next-state logic plus the per-cycle arm/align/accept qualifiers
  always_comb begin
    state_nxt = state;
    arm_entry = 1'b0;
    align     = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt = ST_ARM;
          arm_entry = 1'b1;
        end
      end
      ST_ARM: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (sync) begin
          state_nxt = ST_RUN;
          align     = 1'b1;
          accept    = rx_valid;
        end
      end
      ST_RUN: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else begin
          align  = sync;
          accept = rx_valid;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered armed/running flags
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      armed   <= 1'b0;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      armed   <= (state_nxt == ST_ARM);
      running <= (state_nxt == ST_RUN);
    end
  end

  // Packing datapath: hold register, phase, output word and counters
  always_ff @(posedge Sclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_IQ16;
      phase    <= 1'b0;
      hold     <= '0;
      dout     <= '0;
      dout_en  <= 1'b0;
      smp_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      dout_en <= 1'b0;
      if (arm_entry) begin
        mode_q   <= mode;
        phase    <= 1'b0;
        hold     <= '0;
        smp_cnt  <= '0;
        word_cnt <= '0;
      end else if (!en) begin
        phase <= 1'b0;
        hold  <= '0;
      end else begin
        if (align) begin
          phase <= 1'b0;
        end
        if (accept) begin
          smp_cnt <= smp_cnt + 32'd1;
          if (mode_q == MODE_IQ16) begin
            dout     <= word16;
            dout_en  <= 1'b1;
            word_cnt <= word_cnt + 32'd1;
          end else if (phase && !align) begin
            dout     <= {pair8, hold};
            dout_en  <= 1'b1;
            word_cnt <= word_cnt + 32'd1;
            phase    <= 1'b0;
          end else begin
            hold  <= pair8;
            phase <= 1'b1;
          end
        end
      end
    end
  end

endmodule
